port_req: RTL and testbench
===========================

Name: port_req

Overview:
- Per-input-port request controller for the multi-port cache.
- Pops the head entry of its packet queue and receives the entry's destination output port.
- Raises a one-hot request toward that port's arbiter, reports the granted port, then issues a port-clear once the packet read finishes.
- One instance per input port, between the input queue and the 16 output-port arbiters.

Parameters:
- PORT_NUM, 16, number of output ports (width of request/ready/response vectors).
- PORT_W, $clog2(PORT_NUM), width of port index fields.

Ports:
- i_clk  input  1  clock, all logic on rising edge.
- i_rst_n  input  1  synchronous reset, active-high. Asserted = 1 despite the suffix.
- i_que_vld  input  1  pulse: a new entry was written into the queue.
- i_empty  input  1  queue empty flag.
- i_port_ready  input  PORT_NUM  per-output-port ready (port can accept a new request).
- i_resp  input  PORT_NUM  arbiter grant vector.
- i_port  input  PORT_W  destination port of the popped entry.
- i_port_vld  input  1  qualifies i_port.
- i_r_finish  input  1  pulse: data read of current packet complete.
- o_update  output  1  one-cycle pop strobe to queue.
- o_port_vld  output  1  one-cycle strobe: grant obtained.
- o_port  output  PORT_W  granted port index.
- o_clr_port  output  PORT_W  port to release.
- o_clr_vld  output  1  one-cycle release strobe.
- o_req  output  PORT_NUM  one-hot request vector.

Behaviour:
- All outputs are registered.
- Reset (i_rst_n=1 at a rising edge):
  - state=IDLE, pending=0, latched port=0.
  - All outputs 0.
  - Reset mid-operation aborts immediately; o_req drops the next cycle.
- pending flag:
  - Set by i_que_vld in any state, so an entry arriving while busy is not lost.
  - Cleared when o_update is issued.
- IDLE: if (pending | i_que_vld) & ~i_empty, go to UPD.
  - If i_empty=1, stay IDLE; pending is retained.
- UPD:
  - o_update=1 for exactly this one cycle.
  - Go to WAIT_PORT.
- WAIT_PORT:
  - Wait for i_port_vld=1.
  - On i_port_vld, latch i_port and go to REQ.
  - i_port is ignored while i_port_vld=0.
- REQ:
  - o_req = one-hot(latched port) while i_port_ready[port]=1, otherwise 0.
  - Re-asserts automatically when ready returns.
  - First o_req assertion is 1 cycle after i_port_vld.
  - When i_resp[port]=1 is sampled: next cycle o_req=0, o_port_vld=1, o_port=port; go to BUSY.
  - i_resp bits other than the latched port are ignored.
  - i_resp equal to the current o_req vector counts as a grant.
- BUSY:
  - Wait for i_r_finish.
  - On i_r_finish: next cycle o_clr_vld=1 and o_clr_port=port for one cycle; go to IDLE.
  - i_r_finish in any other state is ignored.
- Strobe widths: o_update, o_port_vld and o_clr_vld are single-cycle pulses.
- Held values: o_port and o_clr_port hold their last value between strobes.
- o_req is at most one-hot at all times, and is 0 outside REQ.
- At most one packet is in flight; there is no pipelining across packets.
- Simultaneous i_que_vld during the UPD cycle: the new pulse sets pending for the next packet (clear and set in the same cycle → set wins).

Test Plan:
- Reset held 1 cycle, i_port_ready=16'hFFFF, i_empty=0 → all outputs 0 during reset and while idle with no i_que_vld.
- Single i_que_vld pulse; bench answers o_update with i_port=15/i_port_vld the next cycle → o_update pulses once, then o_req=16'h8000 one cycle after i_port_vld.
- Continuing: bench echoes i_resp=o_req → o_req=0 and o_port_vld=1 with o_port=15 one cycle after i_resp; no further o_update without a new i_que_vld.
- i_r_finish pulse in BUSY → o_clr_vld=1, o_clr_port=15 one cycle later; back to IDLE.
- i_port=3 with i_port_ready[3]=0 for 4 cycles → o_req stays 0, then 16'h0008 the cycle after ready rises; i_resp=16'h0010 ignored.
- i_que_vld while BUSY with i_empty=1 → no o_update. Clear i_empty after return to IDLE → o_update issued from the pending flag. Reset asserted in REQ → o_req=0 next cycle.

Source files
------------

// File: rtl/port_req.sv
`default_nettype none
// ============================================================================
// Module   : port_req
// Purpose  : Per-input-port request controller. It pops a queue entry,
//            requests the destination output port and releases that port
//            once the packet read completes.
// Revision : 1.0 - initial release
// ============================================================================
module port_req #(
    parameter int PORT_NUM = 16,
    parameter int PORT_W   = $clog2(PORT_NUM)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_que_vld,
    input  logic                i_empty,
    input  logic [PORT_NUM-1:0] i_port_ready,
    input  logic [PORT_NUM-1:0] i_resp,
    input  logic [PORT_W-1:0]   i_port,
    input  logic                i_port_vld,
    input  logic                i_r_finish,
    output logic                o_update,
    output logic                o_port_vld,
    output logic [PORT_W-1:0]   o_port,
    output logic [PORT_W-1:0]   o_clr_port,
    output logic                o_clr_vld,
    output logic [PORT_NUM-1:0] o_req
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_UPD       = 3'd1,
        S_WAIT_PORT = 3'd2,
        S_REQ       = 3'd3,
        S_BUSY      = 3'd4
    } state_t;

    localparam logic [PORT_NUM-1:0] C_ONE = PORT_NUM'(1);

    state_t                state_q,    state_d;
    logic                  pending_q,  pending_d;
    logic [PORT_W-1:0]     port_q,     port_d;
    logic                  update_q,   update_d;
    logic                  port_vld_q, port_vld_d;
    logic [PORT_W-1:0]     gnt_port_q, gnt_port_d;
    logic                  clr_vld_q,  clr_vld_d;
    logic [PORT_W-1:0]     clr_port_q, clr_port_d;
    logic [PORT_NUM-1:0]   req_q,      req_d;

    always_comb begin
        state_d    = state_q;
        port_d     = port_q;
        update_d   = 1'b0;
        port_vld_d = 1'b0;
        gnt_port_d = gnt_port_q;
        clr_vld_d  = 1'b0;
        clr_port_d = clr_port_q;
        req_d      = '0;

        // A pulse arriving in the pop cycle must survive the clear.
        if (state_q == S_UPD) begin
            pending_d = i_que_vld;
        end else begin
            pending_d = pending_q | i_que_vld;
        end

        case (state_q)
            S_IDLE: begin
                if ((pending_q | i_que_vld) & ~i_empty) begin
                    state_d  = S_UPD;
                    update_d = 1'b1;
                end
            end
            S_UPD: begin
                state_d = S_WAIT_PORT;
            end
            S_WAIT_PORT: begin
                if (i_port_vld) begin
                    port_d  = i_port;
                    state_d = S_REQ;
                    if (i_port_ready[i_port]) begin
                        req_d = C_ONE << i_port;
                    end
                end
            end
            S_REQ: begin
                if (i_resp[port_q]) begin
                    port_vld_d = 1'b1;
                    gnt_port_d = port_q;
                    state_d    = S_BUSY;
                end else if (i_port_ready[port_q]) begin
                    req_d = C_ONE << port_q;
                end
            end
            S_BUSY: begin
                if (i_r_finish) begin
                    clr_vld_d  = 1'b1;
                    clr_port_d = port_q;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            state_q    <= S_IDLE;
            pending_q  <= 1'b0;
            port_q     <= '0;
            update_q   <= 1'b0;
            port_vld_q <= 1'b0;
            gnt_port_q <= '0;
            clr_vld_q  <= 1'b0;
            clr_port_q <= '0;
            req_q      <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            port_q     <= port_d;
            update_q   <= update_d;
            port_vld_q <= port_vld_d;
            gnt_port_q <= gnt_port_d;
            clr_vld_q  <= clr_vld_d;
            clr_port_q <= clr_port_d;
            req_q      <= req_d;
        end
    end

    assign o_update   = update_q;
    assign o_port_vld = port_vld_q;
    assign o_port     = gnt_port_q;
    assign o_clr_vld  = clr_vld_q;
    assign o_clr_port = clr_port_q;
    assign o_req      = req_q;

endmodule
`default_nettype wire

// File: tb/tb_port_req.sv
`default_nettype none
// ============================================================================
// Module   : tb_port_req
// Purpose  : Randomized packet-level bench for port_req.
// Revision : 1.0 - initial release
// ============================================================================
module tb_port_req;

    localparam int PN = 16;
    localparam int PW = 4;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_que_vld;
    logic          i_empty;
    logic [PN-1:0] i_port_ready;
    logic [PN-1:0] i_resp;
    logic [PW-1:0] i_port;
    logic          i_port_vld;
    logic          i_r_finish;
    logic          o_update;
    logic          o_port_vld;
    logic [PW-1:0] o_port;
    logic [PW-1:0] o_clr_port;
    logic          o_clr_vld;
    logic [PN-1:0] o_req;

    int n_chk = 0;
    int n_err = 0;
    int last_gnt = 0;
    int last_clr = 0;

    port_req #(.PORT_NUM(PN), .PORT_W(PW)) u_dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_que_vld    (i_que_vld),
        .i_empty      (i_empty),
        .i_port_ready (i_port_ready),
        .i_resp       (i_resp),
        .i_port       (i_port),
        .i_port_vld   (i_port_vld),
        .i_r_finish   (i_r_finish),
        .o_update     (o_update),
        .o_port_vld   (o_port_vld),
        .o_port       (o_port),
        .o_clr_port   (o_clr_port),
        .o_clr_vld    (o_clr_vld),
        .o_req        (o_req)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [PN-1:0] onehot(input int p);
        logic [PN-1:0] one;
        one = 1;
        return one << p;
    endfunction

    // Strobes and request quiet, held port fields at their last value.
    task automatic check_quiet(input string tag);
        check({tag, "_update"},   32'(o_update),   0);
        check({tag, "_port_vld"}, 32'(o_port_vld), 0);
        check({tag, "_clr_vld"},  32'(o_clr_vld),  0);
        check({tag, "_req"},      32'(o_req),      0);
        check({tag, "_port"},     32'(o_port),     32'(last_gnt));
        check({tag, "_clr_port"}, 32'(o_clr_port), 32'(last_clr));
    endtask

    // One complete packet: pop, port lookup, request/grant, read, release.
    task automatic packet(input int p, input int n_gap, input int n_low, input int n_req,
                          input int n_busy, input bit auto_start, input bit vld_in_upd,
                          input bit vld_in_busy);
        logic          rdy;
        logic [PN-1:0] noise;
        if (!auto_start) i_que_vld = 1'b1;
        step();
        i_que_vld = 1'b0;
        check("pop_update", 32'(o_update), 1);
        check("pop_req",    32'(o_req),    0);
        if (vld_in_upd) i_que_vld = 1'b1;
        for (int g = 0; g <= n_gap; g++) begin
            i_port     = PW'($urandom);
            i_port_vld = 1'b0;
            step();
            i_que_vld = 1'b0;
            check_quiet("wait");
        end
        i_port       = PW'(p);
        i_port_vld   = 1'b1;
        rdy          = (n_low == 0);
        i_port_ready = (PN'($urandom) & ~onehot(p)) | (rdy ? onehot(p) : '0);
        step();
        i_port_vld = 1'b0;
        i_port     = PW'($urandom);
        check("first_req", 32'(o_req), 32'(rdy ? onehot(p) : '0));
        for (int k = 1; k <= n_low + n_req; k++) begin
            rdy          = (k >= n_low) ? ($urandom_range(0, 3) != 0) : 1'b0;
            i_port_ready = (PN'($urandom) & ~onehot(p)) | (rdy ? onehot(p) : '0);
            i_resp       = PN'($urandom) & ~onehot(p);
            step();
            check("req", 32'(o_req), 32'(rdy ? onehot(p) : '0));
            check("req_no_gnt", 32'(o_port_vld), 0);
        end
        noise  = PN'($urandom);
        i_resp = $urandom_range(0, 1) ? onehot(p) : (noise | onehot(p));
        step();
        last_gnt = p;
        check("gnt_req",      32'(o_req),      0);
        check("gnt_port_vld", 32'(o_port_vld), 1);
        check("gnt_port",     32'(o_port),     32'(p));
        for (int b = 0; b < n_busy; b++) begin
            i_resp = PN'($urandom);
            if (vld_in_busy && b == 0) begin
                i_empty   = 1'b1;
                i_que_vld = 1'b1;
            end
            step();
            i_que_vld = 1'b0;
            check_quiet("busy");
        end
        i_resp     = '0;
        i_r_finish = 1'b1;
        step();
        i_r_finish = 1'b0;
        last_clr   = p;
        check("clr_vld",  32'(o_clr_vld),  1);
        check("clr_port", 32'(o_clr_port), 32'(p));
        check("clr_req",  32'(o_req),      0);
        if (!vld_in_upd) begin
            step();
            check_quiet("post_clr");
        end
    endtask

    initial begin
        bit pend;
        i_rst_n      = 1'b1;
        i_que_vld    = 1'b0;
        i_empty      = 1'b0;
        i_port_ready = 16'hFFFF;
        i_resp       = '0;
        i_port       = '0;
        i_port_vld   = 1'b0;
        i_r_finish   = 1'b0;
        step();
        check_quiet("reset");
        i_rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_quiet("idle");
        end

        packet(15, 0, 0, 0, 2, 1'b0, 1'b0, 1'b0);
        // Ready withheld on port 3 for four cycles, neighbour grant bits ignored.
        packet(3, 1, 4, 2, 1, 1'b0, 1'b0, 1'b0);
        // Request while busy with the queue empty must wait for data.
        packet(7, 0, 0, 1, 2, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            check_quiet("empty_hold");
        end
        i_empty = 1'b0;
        packet(9, 0, 1, 1, 1, 1'b1, 1'b0, 1'b0);

        pend = 1'b0;
        for (int t = 0; t < 25; t++) begin
            bit nxt;
            nxt = ($urandom_range(0, 3) == 0);
            packet($urandom_range(0, PN - 1), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 4), $urandom_range(0, 3), pend, nxt, 1'b0);
            pend = nxt;
        end
        if (pend) begin
            packet(0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
        end

        // Reset asserted while requesting.
        i_que_vld = 1'b1;
        step();
        i_que_vld = 1'b0;
        step();
        i_port       = 4'd5;
        i_port_vld   = 1'b1;
        i_port_ready = 16'hFFFF;
        step();
        i_port_vld = 1'b0;
        check("rst_pre_req", 32'(o_req), 32'h0020);
        i_rst_n = 1'b1;
        step();
        i_rst_n  = 1'b0;
        last_gnt = 0;
        last_clr = 0;
        check_quiet("rst_mid");
        step();
        check_quiet("after_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
